data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL expose: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  input  1  synchronous, active-high reset sampled on rising edge of clk.
REQ-003 SHALL expose: a_req  input  1  requester A (CPU) access request, level, held until a_ack.
REQ-004 SHALL expose: a_we  input  1  requester A write (1) / read (0).
REQ-005 SHALL expose: a_address  input  8  requester A byte address.
REQ-006 SHALL expose: a_data_in  input  8  requester A write data.
REQ-007 SHALL expose: a_ack  output  1  one-cycle completion pulse to A.
REQ-008 SHALL expose: a_data_out  output  8  registered read data to A, valid while a_ack=1 and held until next A read.
REQ-009 SHALL expose: b_req, b_we, b_address, b_data_in, b_ack, b_data_out  same directions/widths/meanings for requester B (DMA/debug).
REQ-010 SHALL expose: mem_address  output  8  to the 256x8 data memory address port.
REQ-011 SHALL expose: mem_data_in  output  8  to memory write-data port.
REQ-012 SHALL expose: mem_write_enable  output  1  to memory write-enable port.
REQ-013 SHALL expose: mem_data_out  input  8  combinational read data from memory.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, ACK; transitions IDLE->ACCESS when any req=1, ACCESS->ACK unconditionally, ACK->IDLE unconditionally.
REQ-015 SHALL, in IDLE on a granting edge, latch grantee id, we, address, data_in into internal registers; ACCESS and ACK use only latched values.
REQ-016 SHALL drive mem_address/mem_data_in from latched values in ACCESS, and mem_write_enable = latched we in ACCESS only.
REQ-017 SHALL drive mem_address=0x00, mem_data_in=0x00, mem_write_enable=0 in IDLE and ACK.
REQ-018 SHALL, on the edge ending ACCESS for a read, load grantee's data_out register with mem_data_out; writes leave both data_out registers unchanged.
REQ-019 SHALL assert exactly one of a_ack/b_ack (the grantee's) for the single ACK cycle; latency from req sampled in IDLE at edge N to ack high = cycle N+2; throughput one access per 3 cycles.
REQ-020 SHALL ignore req inputs in ACCESS and ACK; a req still high in ACK is treated as a new request in the following IDLE.
REQ-021 SHALL arbitrate simultaneous a_req and b_req round-robin: grant the requester not granted most recently; last-grant pointer updates only on grant.
REQ-022 SHALL grant a lone requester immediately regardless of pointer.
REQ-023 SHALL complete an access whose req drops during ACCESS (latched values used; ack still pulses).
REQ-024 SHALL force mem_write_enable=0 combinationally in any cycle where reset=1, so reset mid-ACCESS commits no write.

Reset
REQ-025 SHALL, on reset, set state=IDLE, a_ack=b_ack=0, a_data_out=b_data_out=0x00, latched registers=0, last-grant pointer=B (A wins first tie).
REQ-026 SHALL leave memory contents untouched by reset.

Configuration
REQ-027 SHALL, when macro DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN is defined, replace round-robin with fixed priority: A always wins ties, pointer logic absent; when undefined, REQ-021 round-robin applies.

Verification
REQ-028 SHALL cover: A write 0x5A to 0x10, then A read 0x10 -> mem_write_enable=1 one cycle with mem_address=0x10; read ack at N+2 with a_data_out=0x5A.
REQ-029 SHALL cover: a_req and b_req held high together, four accesses -> grant order A,B,A,B (with FIXED_PRIORITY_EN: A,A,A,A).
REQ-030 SHALL cover: b_req alone, read 0xFF preloaded 0x3C -> b_ack at N+2, b_data_out=0x3C, a_ack stays 0, a_data_out unchanged.
REQ-031 SHALL cover: reset asserted during ACCESS of A write 0x77 to 0x20 -> mem_write_enable=0, mem[0x20] unchanged, next cycle state IDLE, acks 0.
REQ-032 SHALL cover: a_req dropped during ACCESS of read 0x05 -> a_ack still pulses once, a_data_out=mem[0x05]; no second access follows.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Shares one 256x8 single-port data memory between requester A (CPU) and
// requester B (DMA/debug). Each access takes three cycles:
//   IDLE   : pick a grantee and capture its request
//   ACCESS : drive the memory from the captured request
//   ACK    : pulse the grantee's ack
// Ties go round-robin by default. Define DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
// to make A always win ties instead; the last-grant pointer is then removed.
module data_memory_arbiter (
  input  logic       clk,
  input  logic       reset,
  // requester A
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_address,
  input  logic [7:0] a_data_in,
  output logic       a_ack,
  output logic [7:0] a_data_out,
  // requester B
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_address,
  input  logic [7:0] b_data_in,
  output logic       b_ack,
  output logic [7:0] b_data_out,
  // memory port
  output logic [7:0] mem_address,
  output logic [7:0] mem_data_in,
  output logic       mem_write_enable,
  input  logic [7:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t     state;
  logic       grant_b;       // grantee of the access in flight: 1 = B, 0 = A
  logic       lat_we;
  logic [7:0] lat_address;
  logic [7:0] lat_data_in;
  logic       any_req;
  logic       pick_b;        // grantee chosen if a grant happens this cycle

  assign any_req = a_req | b_req;

`ifdef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
  // A wins every tie; B is granted only when it asks alone.
  assign pick_b = b_req & ~a_req;
`else
  logic last_b;              // 1 when B received the most recent grant

  // A lone requester wins outright; on a tie, the side not granted last wins.
  assign pick_b = b_req & (~a_req | ~last_b);

  // Last-grant pointer moves only when a grant is actually issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b <= 1'b1;        // pretend B went last so A wins the first tie
    end else if (state == IDLE && any_req) begin
      last_b <= pick_b;
    end
  end
`endif

  // Memory port is driven only during ACCESS and parked at zero otherwise.
  // NOTE: write enable is gated with reset combinationally, not through a
  // register, so an access interrupted by reset cannot commit its write in
  // the same cycle the reset is applied.
  assign mem_address      = (state == ACCESS) ? lat_address : 8'h00;
  assign mem_data_in      = (state == ACCESS) ? lat_data_in : 8'h00;
  assign mem_write_enable = (state == ACCESS) & lat_we & ~reset;

  // Access sequencer: captures the request, registers read data and acks.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_b     <= 1'b0;
      lat_we      <= 1'b0;
      lat_address <= 8'h00;
      lat_data_in <= 8'h00;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_data_out  <= 8'h00;
      b_data_out  <= 8'h00;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_b     <= pick_b;
            lat_we      <= pick_b ? b_we      : a_we;
            lat_address <= pick_b ? b_address : a_address;
            lat_data_in <= pick_b ? b_data_in : a_data_in;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // Requests are ignored here; the captured values finish the job.
          if (!lat_we) begin
            if (grant_b) b_data_out <= mem_data_out;
            else         a_data_out <= mem_data_out;
          end
          a_ack <= ~grant_b;
          b_ack <= grant_b;
          state <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model
// (reference memory array, last-winner flag and per-requester read data).
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_address, a_data_in, b_address, b_data_in;
  logic       a_ack, b_ack;
  logic [7:0] a_data_out, b_data_out;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_write_enable;

  int vectors     = 0;
  int miscompares = 0;

  // Memory attached to the DUT, with a preload port used by the bench.
  logic [7:0] mem [0:255];
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = 8'h00, pre_data = 8'h00;

  // Reference model state.
  logic [7:0] ref_mem [0:255];
  logic       model_last_b;
  logic [7:0] model_a_dout, model_b_dout;

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_address];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write_enable) mem[mem_address] <= mem_data_in;
  end

  data_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_address(a_address), .a_data_in(a_data_in),
    .a_ack(a_ack), .a_data_out(a_data_out),
    .b_req(b_req), .b_we(b_we), .b_address(b_address), .b_data_in(b_data_in),
    .b_ack(b_ack), .b_data_out(b_data_out),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Writes both the attached memory and the reference memory.
  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge clk);
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  // One full access: drive in IDLE, check ACCESS, ACK and the following IDLE.
  // Called and returns at a falling edge while the DUT is idle.
  task automatic run_access(
    input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
    input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
    input logic drop, input logic hold, input string tag);
    logic       exp_b, exp_we;
    logic [7:0] exp_addr, exp_data;
    a_req = ar; a_we = aw; a_address = aa; a_data_in = ad;
    b_req = br; b_we = bw; b_address = ba; b_data_in = bd;
`ifdef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
    exp_b = br && !ar;
`else
    exp_b = br && (!ar || !model_last_b);
    model_last_b = exp_b;
`endif
    exp_we   = exp_b ? bw : aw;
    exp_addr = exp_b ? ba : aa;
    exp_data = exp_b ? bd : ad;

    @(posedge clk);            // grant edge N
    @(negedge clk);            // ACCESS cycle
    vectors++;
    if (mem_address !== exp_addr) begin
      miscompares++;
      $display("FAIL %s access mem_address: got %h expected %h", tag, mem_address, exp_addr);
    end
    vectors++;
    if (mem_write_enable !== exp_we) begin
      miscompares++;
      $display("FAIL %s access mem_write_enable: got %b expected %b", tag, mem_write_enable, exp_we);
    end
    vectors++;
    if (mem_data_in !== exp_data) begin
      miscompares++;
      $display("FAIL %s access mem_data_in: got %h expected %h", tag, mem_data_in, exp_data);
    end
    vectors++;
    if ({a_ack, b_ack} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s access acks: got %b%b expected 00", tag, a_ack, b_ack);
    end
    if (drop) begin a_req = 1'b0; b_req = 1'b0; end

    @(posedge clk);            // edge N+1 ends ACCESS
    if (exp_we) ref_mem[exp_addr] = exp_data;
    else if (exp_b) model_b_dout = ref_mem[exp_addr];
    else model_a_dout = ref_mem[exp_addr];
    @(negedge clk);            // ACK cycle, observed before edge N+2
    vectors++;
    if ({a_ack, b_ack} !== {!exp_b, exp_b}) begin
      miscompares++;
      $display("FAIL %s ack a/b: got %b%b expected %b%b", tag, a_ack, b_ack, !exp_b, exp_b);
    end
    vectors++;
    if (a_data_out !== model_a_dout) begin
      miscompares++;
      $display("FAIL %s a_data_out: got %h expected %h", tag, a_data_out, model_a_dout);
    end
    vectors++;
    if (b_data_out !== model_b_dout) begin
      miscompares++;
      $display("FAIL %s b_data_out: got %h expected %h", tag, b_data_out, model_b_dout);
    end
    vectors++;
    if ({mem_address, mem_data_in, mem_write_enable} !== 17'h0) begin
      miscompares++;
      $display("FAIL %s ack-cycle mem port: got %h/%h/%b expected 0", tag,
               mem_address, mem_data_in, mem_write_enable);
    end
    vectors++;
    if (mem[exp_addr] !== ref_mem[exp_addr]) begin
      miscompares++;
      $display("FAIL %s memory[%h]: got %h expected %h", tag, exp_addr, mem[exp_addr], ref_mem[exp_addr]);
    end
    if (!hold) begin a_req = 1'b0; b_req = 1'b0; end

    @(posedge clk);            // edge N+2 ends ACK
    @(negedge clk);            // IDLE cycle
    vectors++;
    if ({a_ack, b_ack, mem_write_enable} !== 3'b000 || mem_address !== 8'h00) begin
      miscompares++;
      $display("FAIL %s idle after ack: got ack %b%b we %b addr %h expected 0", tag,
               a_ack, b_ack, mem_write_enable, mem_address);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_address = 8'h00; a_data_in = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_address = 8'h00; b_data_in = 8'h00;
    @(negedge clk);
    // Fill memory with random contents while the DUT is held in reset.
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));
    vectors++;
    if ({a_ack, b_ack, a_data_out, b_data_out} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset outputs: got ack %b%b dout %h/%h expected 0", a_ack, b_ack, a_data_out, b_data_out);
    end
    vectors++;
    if ({mem_address, mem_data_in, mem_write_enable} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset mem port: got %h/%h/%b expected 0", mem_address, mem_data_in, mem_write_enable);
    end
    reset = 1'b0;
    model_last_b = 1'b1;
    model_a_dout = 8'h00;
    model_b_dout = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    run_access(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "a_write");
    run_access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "a_read");
    vectors++;
    if (a_data_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL a_read_back: got %h expected 5a", a_data_out);
    end
  endtask

  task automatic test_tie_order();
    for (int i = 0; i < 4; i++)
      run_access(1'b1, 1'b0, 8'(8'h40 + i), 8'h00, 1'b1, 1'b0, 8'(8'h80 + i), 8'h00,
                 1'b0, (i != 3), "tie");
  endtask

  task automatic test_b_read();
    preload(8'hFF, 8'h3C);
    run_access(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, "b_read");
    vectors++;
    if (b_data_out !== 8'h3C) begin
      miscompares++;
      $display("FAIL b_read_value: got %h expected 3c", b_data_out);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] old_val;
    old_val = ref_mem[8'h20];
    a_req = 1'b1; a_we = 1'b1; a_address = 8'h20; a_data_in = 8'h77;
    @(posedge clk);
    @(negedge clk);            // ACCESS of the write
    vectors++;
    if (mem_write_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset pre-check we: got %b expected 1", mem_write_enable);
    end
    reset = 1'b1;
    a_req = 1'b0;
    #1;
    vectors++;
    if (mem_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset we gating: got %b expected 0", mem_write_enable);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_last_b = 1'b1;
    model_a_dout = 8'h00;
    model_b_dout = 8'h00;
    vectors++;
    if (mem[8'h20] !== old_val) begin
      miscompares++;
      $display("FAIL mid_reset memory: got %h expected %h", mem[8'h20], old_val);
    end
    vectors++;
    if ({a_ack, b_ack, mem_address} !== 10'h0) begin
      miscompares++;
      $display("FAIL mid_reset idle: got ack %b%b addr %h expected 0", a_ack, b_ack, mem_address);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({a_ack, b_ack, mem_address} !== 10'h0) begin
      miscompares++;
      $display("FAIL mid_reset no_ack: got ack %b%b addr %h expected 0", a_ack, b_ack, mem_address);
    end
  endtask

  task automatic test_req_drop();
    run_access(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, "a_drop");
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({a_ack, b_ack, mem_address} !== 10'h0) begin
      miscompares++;
      $display("FAIL a_drop second access: got ack %b%b addr %h expected 0", a_ack, b_ack, mem_address);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic ar, br;
      ar = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      if (!ar && !br) ar = 1'b1;
      run_access(ar, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 br, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie_order();
    test_b_read();
    test_reset_mid_access();
    test_req_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
